// File: rtl/hash_pkg.sv
// Shared definitions for the Keccak squeeze sequencer: FSM encoding and
// rate/word geometry of the 1344-bit output buffer.
package hash_pkg;
  localparam int HASH_RATE_WORDS = 21;
  localparam int HASH_WORD_W     = 64;

  typedef enum logic [1:0] {
    SQZ_IDLE,
    SQZ_PERM,
    SQZ_DRAIN,
    SQZ_FIN
  } sqz_state_e;
endpackage

// File: rtl/hash_sqz_skid.sv
// One-entry output register slice for the squeeze stream. Accepts a new word
// whenever it is empty or its current word is leaving in the same cycle.
module hash_sqz_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end
endmodule

// File: rtl/hash_squeeze_ctrl.sv
// Squeeze-phase sequencer: issues permutations and streams buffer words out.
// Define HASH_SQZ_SKID_EN to register the output stream through hash_sqz_skid.
module hash_squeeze_ctrl
  import hash_pkg::*;
#(
  parameter int RATE_WORDS = HASH_RATE_WORDS,
  parameter int LEN_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       num_words,
  output logic                   perm_start,
  input  logic                   perm_done,
  output logic                   dout_en,
  input  logic [HASH_WORD_W-1:0] hash_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [HASH_WORD_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);
  localparam int CNT_W = $clog2(RATE_WORDS + 1);

  sqz_state_e       state;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] word_cnt;
  logic             fire;
  logic             final_xfer;
  logic             blk_end;

  assign blk_end = (word_cnt == CNT_W'(RATE_WORDS - 1));

`ifdef HASH_SQZ_SKID_EN
  logic src_valid;
  logic src_ready;
  logic src_last;

  // Fetch from the buffer while words remain; the slice decouples out_ready.
  assign src_valid  = (state == SQZ_DRAIN) && (remaining != '0);
  assign src_last   = (remaining == LEN_W'(1));
  assign fire       = src_valid & src_ready;
  assign final_xfer = out_valid & out_ready & out_last;

  hash_sqz_skid #(.W(HASH_WORD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (src_valid),
    .in_data   (hash_in),
    .in_last   (src_last),
    .in_ready  (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );
`else
  assign out_valid  = (state == SQZ_DRAIN);
  assign fire       = out_valid & out_ready;
  assign out_data   = out_valid ? hash_in : '0;
  assign out_last   = out_valid && (remaining == LEN_W'(1));
  assign final_xfer = fire && (remaining == LEN_W'(1));
`endif

  assign dout_en = fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SQZ_IDLE;
      remaining  <= '0;
      word_cnt   <= '0;
      perm_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      perm_start <= 1'b0;
      case (state)
        SQZ_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words == '0) begin
              state <= SQZ_FIN;
            end else begin
              remaining  <= num_words;
              word_cnt   <= '0;
              perm_start <= 1'b1;
              state      <= SQZ_PERM;
            end
          end
        end
        SQZ_PERM: begin
          if (perm_done) state <= SQZ_DRAIN;
        end
        SQZ_DRAIN: begin
          if (fire) begin
            remaining <= remaining - LEN_W'(1);
            if (blk_end) begin
              word_cnt <= '0;
              // A block that ends the request needs no further permutation.
              if (remaining != LEN_W'(1)) begin
                perm_start <= 1'b1;
                state      <= SQZ_PERM;
              end
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
          if (final_xfer) begin
            done  <= 1'b1;
            state <= SQZ_FIN;
          end
        end
        SQZ_FIN: begin
          // Zero-length requests arrive with done low and pulse it one cycle later.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= SQZ_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= SQZ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_squeeze_ctrl.sv
// Scoreboard bench for hash_squeeze_ctrl: a behavioural round engine feeds
// tagged buffer words, a monitor pops expected words on every transfer.
module tb_hash_squeeze_ctrl;
  localparam int RW = 21;
  localparam int LW = 16;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] num_words;
  logic          perm_start;
  logic          perm_done;
  logic          dout_en;
  logic [63:0]   hash_in;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  hash_squeeze_ctrl #(.RATE_WORDS(RW), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .dout_en    (dout_en),
    .hash_in    (hash_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc = 0;
  int   perm_cnt = 0;
  int   dout_cnt = 0;
  int   last_cyc = 0;
  bit   exp_perm = 0;
  exp_t exp_q[$];
  exp_t e;

  function automatic logic [63:0] word(input int b, input int p);
    return {16'hC0DE, 16'(b), 16'h0000, 16'(p)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Round engine model: perm_done three cycles after perm_start, buffer tagged
  // with the permutation index, pointer advanced by dout_en.
  int   n_perm = 0;
  int   pend_id = 0;
  int   blk = 0;
  int   ptr = 0;
  int   eng_cnt = 0;
  logic eng_done = 1'b0;
  logic spur;

  assign perm_done = eng_done | spur;
  assign hash_in   = word(blk, ptr);

  always @(posedge clk) begin
    ncyc     <= ncyc + 1;
    eng_done <= 1'b0;
    if (perm_start) begin
      pend_id <= n_perm;
      n_perm  <= n_perm + 1;
      eng_cnt <= 3;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        blk      <= pend_id;
        ptr      <= 0;
      end
    end
    if (dout_en) ptr <= ptr + 1;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_perm) begin
        chk("perm_after_block", perm_start, 1);
        exp_perm = 0;
      end
      if (perm_start) perm_cnt++;
      if (dout_en) dout_cnt++;
      if (out_valid && !out_ready) chk("stall_no_dout_en", dout_en, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", out_data, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.d);
          chk("last", out_last, e.l);
          if (e.l) last_cyc = ncyc;
          else if (e.d[15:0] == 16'(RW - 1)) exp_perm = 1;
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic run_req(input int n, input bit rnd, input bit inj, input int abort_after);
    int base, p0, d0, s_cyc, cyc;
    bit seen, injected;
    base = n_perm;
    p0 = perm_cnt;
    d0 = dout_cnt;
    seen = 0;
    injected = 0;
    for (int i = 0; i < n; i++) exp_q.push_back('{word(base + i / RW, i % RW), i == n - 1});
    start = 1'b1;
    num_words = LW'(n);
    s_cyc = ncyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("perm_start_lat", perm_start, (n > 0) ? 1 : 0);
    chk("busy_lat", busy, 1);
    cyc = 0;
    while (!seen && cyc < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && !injected && out_valid) begin
        start = 1'b1;
        num_words = LW'(5);
        spur = 1'b1;
        injected = 1;
      end
      @(negedge clk); #1;
      if (abort_after > 0 && dout_cnt - d0 >= abort_after) break;
      if (done) begin
        seen = 1;
        chk("done_lat", 64'(ncyc), (n == 0) ? 64'(s_cyc + 2) : 64'(last_cyc + 1));
      end
      @(posedge clk); #1;
      start = 1'b0;
      spur = 1'b0;
      cyc++;
    end
    if (abort_after > 0) begin
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_perm_start", perm_start, 0);
      chk("rst_dout_en", dout_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_words_before", dout_cnt - d0, abort_after);
      exp_q.delete();
      exp_perm = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (inj) chk("inject_applied", injected, 1);
    chk("busy_after_done", busy, 0);
    chk("done_pulse", done, 0);
    chk("perm_count", perm_cnt - p0, (n + RW - 1) / RW);
    chk("dout_en_count", dout_cnt - d0, n);
    chk("queue_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    out_ready = 1'b1;
    spur = 1'b0;
    #1;
    chk("reset_perm_start", perm_start, 0);
    chk("reset_dout_en", dout_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(5, 0, 0, 0);
    run_req(21, 0, 0, 0);
    run_req(22, 0, 0, 0);
    run_req(0, 0, 0, 0);
    run_req(50, 1, 0, 0);
    run_req(30, 0, 1, 0);
    run_req(30, 0, 0, 7);
    run_req(3, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
